// File: rtl/fwd_scoreboard.sv
// Operand forwarding for NSTAGE in-flight stages plus completion bypass, with a
// registered busy scoreboard for long-latency ops and decode stall generation.
module fwd_scoreboard #(
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [XLEN-1:0]              id_pc,
  input  logic [NSRC-1:0]              src_valid,
  input  logic [NSRC-1:0][AW-1:0]      src_addr,
  input  logic [NSTAGE-1:0]            stg_valid,
  input  logic [NSTAGE-1:0][XLEN-1:0]  stg_pc,
  input  logic [NSTAGE-1:0]            stg_regwrite,
  input  logic [NSTAGE-1:0][AW-1:0]    stg_dst,
  input  logic [NSTAGE-1:0]            stg_ready,
  input  logic [NSTAGE-1:0][XLEN-1:0]  stg_data,
  input  logic                         issue_valid,
  input  logic [AW-1:0]                issue_dst,
  input  logic                         cpl_valid,
  input  logic [AW-1:0]                cpl_dst,
  input  logic [XLEN-1:0]              cpl_data,
  input  logic                         flush,
  output logic [NSRC-1:0]              fwd_enable,
  output logic [NSRC-1:0][XLEN-1:0]    fwd_data,
  output logic                         stall,
  output logic [NREG-1:0]              busy,
  output logic [31:0]                  stall_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0] stg_hit;
  logic [NSRC-1:0] data_haz;
  logic            waw_haz;

  // Per source: youngest matching stage wins, then completion bypass, then scoreboard.
  always_comb begin
    fwd_enable = '0;
    fwd_data   = '0;
    data_haz   = '0;
    stg_hit    = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (src_valid[s] && src_addr[s] != '0) begin
        for (int unsigned k = 0; k < NSTAGE; k++) begin
          if (!stg_hit[s] && stg_valid[k] && stg_regwrite[k] &&
              stg_dst[k] != '0 && stg_dst[k] == src_addr[s] &&
              stg_pc[k] != id_pc) begin
            stg_hit[s]    = 1'b1;
            fwd_enable[s] = 1'b1;
            fwd_data[s]   = stg_data[k];
            data_haz[s]   = !stg_ready[k];
          end
        end
        if (!stg_hit[s]) begin
          if (cpl_valid && cpl_dst == src_addr[s]) begin
            fwd_enable[s] = 1'b1;
            fwd_data[s]   = cpl_data;
          end else begin
            data_haz[s] = busy_q[src_addr[s]];
          end
        end
      end
    end
  end

  always_comb begin
    waw_haz = issue_valid && busy_q[issue_dst] &&
              !(cpl_valid && cpl_dst == issue_dst);
    stall   = (|data_haz) || waw_haz;
  end

  // Clear on completion, then set on issue (set wins), flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (cpl_valid) begin
      busy_d[cpl_dst] = 1'b0;
    end
    if (issue_valid && !stall && issue_dst != '0) begin
      busy_d[issue_dst] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule
